// File: rtl/id_ex_alu_issue.sv
// ID/EX issue register: decodes the ID instruction into ALU/main controls, registers them for EX,
// and inserts a single bubble on a load-use hazard.
module id_ex_alu_issue #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic             stall_in,
  input  logic             flush,
  output logic             id_ready,
  output logic             hazard,
  output logic             ex_valid,
  output logic [1:0]       ex_aluop,
  output logic [3:0]       ex_funct,
  output logic             ex_alusrc,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             ex_branch,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_bubble,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] bubble_count
);

  typedef enum logic {NORMAL, BUBBLE} state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] aluop;
    logic [3:0] funct;
    logic       alusrc;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       branch;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ex_t;

  state_t state, state_next;
  ex_t    ex_q, load_val;
  logic   uses_rs2, dec_legal, illegal_load;
  logic   unused_bits;

  assign unused_bits = ^{id_instr[31], id_instr[29:25]};

  always_comb begin
    load_val  = '0;
    uses_rs2  = 1'b0;
    dec_legal = 1'b1;
    load_val.funct = {id_instr[30], id_instr[14:12]};
    load_val.rs1   = id_instr[19:15];
    load_val.rs2   = id_instr[24:20];
    load_val.rd    = id_instr[11:7];
    case (id_instr[6:0])
      7'b0110011: begin
        load_val.regwrite = 1'b1;
        load_val.aluop    = 2'b10;
        uses_rs2          = 1'b1;
      end
      7'b0010011: begin
        load_val.regwrite = 1'b1;
        load_val.alusrc   = 1'b1;
        load_val.aluop    = 2'b10;
        load_val.funct[3] = 1'b0;
      end
      7'b0000011: begin
        load_val.regwrite = 1'b1;
        load_val.alusrc   = 1'b1;
        load_val.memread  = 1'b1;
        load_val.memtoreg = 1'b1;
      end
      7'b0100011: begin
        load_val.alusrc   = 1'b1;
        load_val.memwrite = 1'b1;
        uses_rs2          = 1'b1;
      end
      7'b1100011: begin
        load_val.branch = 1'b1;
        load_val.aluop  = 2'b01;
        uses_rs2        = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
    // Unsupported opcodes issue as a valid NOP; an empty ID slot issues as an invalid NOP.
    if (!id_valid || !dec_legal) load_val = '0;
    load_val.valid = id_valid;
  end

  assign illegal_load = id_valid & ~dec_legal;

  assign hazard = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) &
                  ((ex_q.rd == id_instr[19:15]) | (uses_rs2 & (ex_q.rd == id_instr[24:20])));
  assign id_ready = ~stall_in & ~hazard;

  always_comb begin
    state_next = state;
    if (flush)          state_next = NORMAL;
    else if (!stall_in) state_next = hazard ? BUBBLE : NORMAL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= NORMAL;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q          <= '0;
      illegal_instr <= 1'b0;
      bubble_count  <= '0;
    end else if (flush) begin
      ex_q          <= '0;
      illegal_instr <= 1'b0;
    end else if (stall_in) begin
      illegal_instr <= 1'b0;
    end else if (hazard) begin
      ex_q          <= '0;
      illegal_instr <= 1'b0;
      if (bubble_count != {CNT_W{1'b1}}) bubble_count <= bubble_count + CNT_W'(1);
    end else begin
      ex_q          <= load_val;
      illegal_instr <= illegal_load;
    end
  end

  assign ex_bubble   = (state == BUBBLE);
  assign ex_valid    = ex_q.valid;
  assign ex_aluop    = ex_q.aluop;
  assign ex_funct    = ex_q.funct;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_branch   = ex_q.branch;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;

endmodule
